// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants for the MIPS registered N:1 selector.
//            BAD_ZERO / BAD_HOLD encode the out-of-range select policy;
//            ERR_CNT_W is the width of the saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Out-of-range select policy values for BAD_MODE
    localparam int BAD_ZERO  = 0;   // bad beat carries all-zeros data
    localparam int BAD_HOLD  = 1;   // bad beat carries the last good data

    // Error counter width and its saturation value
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : mips_skid_buf
// Purpose  : 2-entry valid/ready skid buffer. The main register M drives the
//            output; the skid register S absorbs one extra beat when the
//            output stalls, so the upstream ready is purely registered state
//            (plus reset) and throughput stays at one beat per cycle.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_payload/valid  - upstream beat
//            in_ready          - block can accept a beat (~S.valid & ~rst)
//            out_payload/valid - head-of-line beat (register M)
//            out_ready         - downstream accepts
// Revision : 1.0 - initial release
// ============================================================================
module mips_skid_buf #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] in_payload,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] out_payload,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [PW-1:0] r_m_data;
    logic          r_m_valid;
    logic [PW-1:0] r_s_data;
    logic          r_s_valid;

    logic w_acc;
    logic w_fire;

    // Ready is forced low while reset is held so nothing is accepted into
    // registers that are being cleared.
    assign in_ready = ~r_s_valid & ~rst;
    assign w_acc    = in_valid & in_ready;
    assign w_fire   = r_m_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_valid <= 1'b0;
        end else begin
            if (w_fire && r_s_valid) begin
                // Skid entry moves up; in_ready was low so no accept here.
                r_m_data  <= r_s_data;
                r_s_valid <= 1'b0;
            end else if (w_acc && (!r_m_valid || w_fire)) begin
                // M empty or draining this cycle: new beat goes straight to M.
                r_m_data  <= in_payload;
                r_m_valid <= 1'b1;
            end else if (w_acc) begin
                // M occupied and stalled: park the beat in S.
                r_s_data  <= in_payload;
                r_s_valid <= 1'b1;
            end else if (w_fire) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign out_payload = r_m_data;
    assign out_valid   = r_m_valid;

endmodule : mips_skid_buf
`default_nettype wire

// File: rtl/mips_muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mips_muxn_pipe
// Purpose  : Registered N:1 selector with valid/ready handshake. Selects one
//            WIDTH-bit slice of in_data by in_sel, tags the beat with the
//            select and an out-of-range flag, and passes it through a 2-entry
//            skid buffer. Out-of-range selects yield zeros or the last good
//            data (BAD_MODE) and are counted in sel_err / err_cnt.
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            in_data, in_sel        - flattened inputs, input index
//            in_valid, in_ready     - upstream handshake
//            out_data, out_src,
//            out_bad                - selected data, captured select, bad flag
//            out_valid, out_ready   - downstream handshake
//            clr_err                - synchronous clear of error state
//            sel_err, err_cnt       - sticky error flag, saturating counter
// Revision : 1.0 - initial release
// ============================================================================
module mips_muxn_pipe
    import mips_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int NUM_IN   = 3,
    parameter  int BAD_MODE = BAD_ZERO,
    localparam int SEL_W    = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_bad,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clr_err,
    output logic                    sel_err,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    localparam int PW = WIDTH + SEL_W + 1;

    logic [WIDTH-1:0]     w_sel_data;
    logic                 w_good;
    logic                 w_acc;
    logic [WIDTH-1:0]     w_beat_data;
    logic [PW-1:0]        w_in_payload;
    logic [PW-1:0]        w_out_payload;
    logic                 w_sb_ready;

    logic [WIDTH-1:0]     r_last_good;
    logic                 r_sel_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_err_base;
    logic [ERR_CNT_W-1:0] w_cnt_base;

    // When NUM_IN fills the select space every code is legal; this avoids a
    // constant-true comparison and keeps the error path statically dead.
    generate
        if (NUM_IN == (1 << SEL_W)) begin : g_pow2
            assign w_good = 1'b1;
        end else begin : g_range
            assign w_good = (32'(in_sel) < NUM_IN);
        end
    endgenerate

    // Index decode; an out-of-range select leaves the default of zero.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_beat_data = w_sel_data;
        if (!w_good) begin
            w_beat_data = (BAD_MODE == BAD_HOLD) ? r_last_good : '0;
        end
    end

    assign w_in_payload = {w_beat_data, in_sel, ~w_good};
    assign w_acc        = in_valid & w_sb_ready;

    mips_skid_buf #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_payload  (w_in_payload),
        .in_valid    (in_valid),
        .in_ready    (w_sb_ready),
        .out_payload (w_out_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    assign in_ready = w_sb_ready;
    assign {out_data, out_src, out_bad} = w_out_payload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_good <= '0;
        end else if (w_acc && w_good) begin
            r_last_good <= w_sel_data;
        end
    end

    // Clear is applied first, then a bad accept in the same cycle counts on
    // top of the cleared value (so clear + bad leaves flag=1, count=1).
    assign w_err_base = clr_err ? 1'b0 : r_sel_err;
    assign w_cnt_base = clr_err ? '0   : r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_acc && !w_good) begin
            r_sel_err <= 1'b1;
            r_err_cnt <= (w_cnt_base == ERR_CNT_MAX) ? w_cnt_base
                                                     : w_cnt_base + 1'b1;
        end else begin
            r_sel_err <= w_err_base;
            r_err_cnt <= w_cnt_base;
        end
    end

    assign sel_err = r_sel_err;
    assign err_cnt = r_err_cnt;

endmodule : mips_muxn_pipe
`default_nettype wire

// File: tb/tb_mips_muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muxn_pipe
// Purpose  : Self-checking bench for mips_muxn_pipe. Three instances share
//            one stimulus: NUM_IN=3 with zero policy, NUM_IN=3 with hold
//            policy, and NUM_IN=4 where every select is legal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_muxn_pipe;

    logic         clk;
    logic         rst;
    logic [95:0]  in_data;
    logic [127:0] in_data4;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         out_ready;
    logic         clr_err;

    logic [31:0] od0, od1, od2;
    logic [1:0]  os0, os1, os2;
    logic        ob0, ob1, ob2;
    logic        ov0, ov1, ov2;
    logic        ir0, ir1, ir2;
    logic        se0, se1, se2;
    logic [7:0]  ec0, ec1, ec2;

    int total = 0;
    int bad   = 0;

    assign in_data4 = {32'h0000_0044, in_data};

    mips_muxn_pipe #(.WIDTH(32), .NUM_IN(3), .BAD_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(ir0), .out_data(od0), .out_src(os0),
        .out_bad(ob0), .out_valid(ov0), .out_ready(out_ready),
        .clr_err(clr_err), .sel_err(se0), .err_cnt(ec0));

    mips_muxn_pipe #(.WIDTH(32), .NUM_IN(3), .BAD_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(ir1), .out_data(od1), .out_src(os1),
        .out_bad(ob1), .out_valid(ov1), .out_ready(out_ready),
        .clr_err(clr_err), .sel_err(se1), .err_cnt(ec1));

    mips_muxn_pipe #(.WIDTH(32), .NUM_IN(4), .BAD_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(ir2), .out_data(od2), .out_src(os2),
        .out_bad(ob2), .out_valid(ov2), .out_ready(out_ready),
        .clr_err(clr_err), .sel_err(se2), .err_cnt(ec2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One record = inputs applied for a cycle, outputs expected after the edge
    typedef struct {
        int vin; int sel; int ordy; int d0;
        int xv;  int xd0; int xd1;  int xsrc; int xbad; int xir;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  src;
        logic        bad;
    } beat_t;

    vec_t  vecs [14];
    beat_t q [$];

    initial begin
        // in-order, backpressure, and bad-select vectors
        vecs[0]  = '{1, 0, 1, 'h11,   1, 'h11,   'h11,   0, 0, 1};
        vecs[1]  = '{1, 1, 1, 'h11,   1, 'h22,   'h22,   1, 0, 1};
        vecs[2]  = '{1, 2, 1, 'h11,   1, 'h33,   'h33,   2, 0, 1};
        vecs[3]  = '{0, 0, 1, 'h11,   0, 0,      0,      0, 0, 1};
        vecs[4]  = '{1, 0, 0, 'h11,   1, 'h11,   'h11,   0, 0, 1};
        vecs[5]  = '{1, 1, 0, 'h11,   1, 'h11,   'h11,   0, 0, 0};
        vecs[6]  = '{1, 2, 0, 'h11,   1, 'h11,   'h11,   0, 0, 0};
        vecs[7]  = '{1, 2, 1, 'h11,   1, 'h22,   'h22,   1, 0, 1};
        vecs[8]  = '{1, 2, 1, 'h11,   1, 'h33,   'h33,   2, 0, 1};
        vecs[9]  = '{0, 0, 1, 'h11,   0, 0,      0,      0, 0, 1};
        vecs[10] = '{1, 0, 1, 'hABCD, 1, 'hABCD, 'hABCD, 0, 0, 1};
        vecs[11] = '{1, 3, 1, 'hABCD, 1, 0,      'hABCD, 3, 1, 1};
        vecs[12] = '{1, 2, 1, 'hABCD, 1, 'h33,   'h33,   2, 0, 1};
        vecs[13] = '{0, 0, 1, 'hABCD, 0, 0,      0,      0, 0, 1};

        rst       = 1'b1;
        in_data   = {32'h33, 32'h22, 32'h11};
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_out_data",  od0, 0);
        chk("rst_out_src",   32'(os0), 0);
        chk("rst_out_bad",   32'(ob0), 0);
        chk("rst_sel_err",   32'(se0), 0);
        chk("rst_err_cnt",   32'(ec0), 0);
        chk("rst_in_ready",  32'(ir0), 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready",  32'(ir0), 1);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 14; i++) begin
            in_valid      = vecs[i].vin[0];
            in_sel        = vecs[i].sel[1:0];
            out_ready     = vecs[i].ordy[0];
            in_data[31:0] = vecs[i].d0;
            step();
            chk($sformatf("vec%0d_valid0", i), 32'(ov0), vecs[i].xv);
            chk($sformatf("vec%0d_valid1", i), 32'(ov1), vecs[i].xv);
            chk($sformatf("vec%0d_in_ready", i), 32'(ir0), vecs[i].xir);
            if (vecs[i].xv != 0) begin
                chk($sformatf("vec%0d_data0", i), od0, vecs[i].xd0);
                chk($sformatf("vec%0d_data1", i), od1, vecs[i].xd1);
                chk($sformatf("vec%0d_src", i), 32'(os0), vecs[i].xsrc);
                chk($sformatf("vec%0d_bad0", i), 32'(ob0), vecs[i].xbad);
                chk($sformatf("vec%0d_bad1", i), 32'(ob1), vecs[i].xbad);
                chk($sformatf("vec%0d_bad_pow2", i), 32'(ob2), 0);
            end
            if (i == 11) chk("vec11_data_pow2", od2, 32'h44);
        end
        chk("one_bad_sel_err", 32'(se0), 1);
        chk("one_bad_err_cnt", 32'(ec0), 1);
        chk("one_bad_err_cnt1", 32'(ec1), 1);

        // ---------------- saturation ----------------
        in_valid = 1'b1;
        in_sel   = 2'd3;
        out_ready = 1'b1;
        repeat (260) step();
        chk("sat_err_cnt0", 32'(ec0), 255);
        chk("sat_err_cnt1", 32'(ec1), 255);
        chk("sat_sel_err",  32'(se0), 1);
        chk("sat_data0",    od0, 0);
        chk("sat_bad0",     32'(ob0), 1);
        chk("sat_data1",    od1, 32'h33);
        chk("sat_pow2_data", od2, 32'h44);
        chk("sat_pow2_bad",  32'(ob2), 0);
        chk("sat_pow2_cnt",  32'(ec2), 0);
        chk("sat_pow2_err",  32'(se2), 0);

        // clear together with a bad beat, then clear alone
        clr_err = 1'b1;
        step();
        chk("clr_bad_err_cnt", 32'(ec0), 1);
        chk("clr_bad_sel_err", 32'(se0), 1);
        in_valid = 1'b0;
        step();
        chk("clr_err_cnt", 32'(ec0), 0);
        chk("clr_sel_err", 32'(se0), 0);
        clr_err = 1'b0;
        step();

        // ---------------- reset mid-transfer ----------------
        in_data   = {32'h33, 32'h22, 32'h11};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        in_sel = 2'd1;
        step();
        chk("full_in_ready", 32'(ir0), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ov0), 0);
        chk("mid_rst_in_ready", 32'(ir0), 0);
        chk("mid_rst_data", od0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(ir0), 1);
        chk("post_rst_valid", 32'(ov0), 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        step();
        chk("post_rst_bad_valid", 32'(ov1), 1);
        chk("post_rst_lastgood", od1, 0);
        chk("post_rst_bad_flag", 32'(ob1), 1);
        chk("post_rst_err_cnt", 32'(ec0), 1);
        in_sel = 2'd1;
        step();
        chk("post_rst_data", od0, 32'h22);
        chk("post_rst_src", 32'(os0), 1);
        in_valid = 1'b0;
        step();
        chk("post_rst_no_stale", 32'(ov0), 0);

        // ---------------- random scoreboard ----------------
        begin
            logic [31:0] lg;
            int nacc, cyc, nbad;
            logic stalled;
            logic [31:0] hd;
            logic [1:0]  hs;
            logic        hb;
            lg = 32'h22;
            nbad = 1;
            nacc = 0;
            cyc = 0;
            stalled = 1'b0;
            hd = '0; hs = '0; hb = 1'b0;
            while (nacc < 10000 && cyc < 60000) begin
                chk("no_x", 32'($isunknown({od0, os0, ob0, ov0, od1})), 0);
                if (stalled) begin
                    chk("stall_valid", 32'(ov0), 1);
                    chk("stall_data", od0, hd);
                    chk("stall_src", 32'(os0), 32'(hs));
                    chk("stall_bad", 32'(ob0), 32'(hb));
                end
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                in_sel    = 2'($urandom_range(0, 3));
                in_data   = {$urandom(), $urandom(), $urandom()};
                #1;
                if (ov0 && out_ready) begin
                    if (q.size() == 0) begin
                        chk("sb_unexpected_beat", 1, 0);
                    end else begin
                        beat_t e;
                        e = q.pop_front();
                        chk("sb_data0", od0, e.d0);
                        chk("sb_data1", od1, e.d1);
                        chk("sb_src", 32'(os0), 32'(e.src));
                        chk("sb_bad", 32'(ob0), 32'(e.bad));
                    end
                end
                if (in_valid && ir0) begin
                    beat_t b;
                    int s;
                    s = int'(in_sel);
                    b.src = in_sel;
                    if (s < 3) begin
                        b.d0  = in_data[s*32 +: 32];
                        b.d1  = b.d0;
                        b.bad = 1'b0;
                        lg    = b.d0;
                    end else begin
                        b.d0  = 32'h0;
                        b.d1  = lg;
                        b.bad = 1'b1;
                        nbad++;
                    end
                    q.push_back(b);
                    nacc++;
                end
                stalled = ov0 & ~out_ready;
                hd = od0; hs = os0; hb = ob0;
                step();
                cyc++;
            end
            chk("rand_beats_done", 32'(nacc), 10000);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int k = 0; k < 10 && q.size() != 0; k++) begin
                if (ov0) begin
                    beat_t e;
                    e = q.pop_front();
                    chk("drain_data0", od0, e.d0);
                    chk("drain_src", 32'(os0), 32'(e.src));
                end
                step();
            end
            chk("drain_empty", 32'(q.size()), 0);
            chk("rand_err_cnt", 32'(ec0), (nbad > 255) ? 255 : nbad);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_muxn_pipe
`default_nettype wire
